minv_job_arbiter: RTL and testbench

//  Shares one Matrix_Inversion_Top core among NREQ requesters, one 3x3 job at a time.

---
 rtl/minv_job_arbiter.sv | 171 +++++++++++++++++
 tb/tb_minv_job_arbiter.sv | 301 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/minv_job_arbiter.sv
// -----------------------------------------------------------------------------
// minv_job_arbiter
//
// Shares one 3x3 matrix-inversion core among NREQ requesters, one job at a time.
// A round-robin grant picks the next requester, its matrix is latched and held
// on the core input while core_start is high, and the core result is returned
// with the requester index over a valid/ready response channel.
//
// Configuration macro: MINV_TIMEOUT_EN
//   defined   : RUN is bounded to TIMEOUT_CYC cycles; an expired job returns a
//               zero matrix with rsp_timeout=1.
//   undefined : RUN waits for core_done indefinitely; rsp_timeout is tied to 0.
//
// Ports
//   clk             in   system clock, rising edge
//   rst             in   asynchronous, active-low reset
//   req_valid       in   [NREQ]        requester i has a job pending
//   req_matrix      in   [NREQ*MAT_W]  job matrix of requester i at [i*MAT_W +: MAT_W]
//   req_ready       out  [NREQ]        one-hot accept (IDLE only)
//   core_start      out                core start, high for the whole job
//   core_matrix     out  [MAT_W]       core matrix_in, stable while core_start=1
//   core_done       in                 core done
//   core_matrix_out in   [MAT_W]       core result, sampled when core_done=1
//   rsp_valid       out                result available
//   rsp_ready       in                 consumer accepts result
//   rsp_id          out  [IDX_W]       requester index of the result
//   rsp_matrix      out  [MAT_W]       inverted matrix
//   rsp_timeout     out                result is a timeout, not a valid inverse
//   busy            out                high in every state other than IDLE
// -----------------------------------------------------------------------------
module minv_job_arbiter #(
    parameter int NREQ        = 4,
    parameter int ELEM_W      = 8,
    parameter int MAT_W       = 9 * ELEM_W,
    parameter int IDX_W       = $clog2(NREQ),
    parameter int TIMEOUT_CYC = 1024
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [NREQ-1:0]         req_valid,
    input  logic [NREQ*MAT_W-1:0]   req_matrix,
    output logic [NREQ-1:0]         req_ready,
    output logic                    core_start,
    output logic [MAT_W-1:0]        core_matrix,
    input  logic                    core_done,
    input  logic [MAT_W-1:0]        core_matrix_out,
    output logic                    rsp_valid,
    input  logic                    rsp_ready,
    output logic [IDX_W-1:0]        rsp_id,
    output logic [MAT_W-1:0]        rsp_matrix,
    output logic                    rsp_timeout,
    output logic                    busy
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_RESP
    } state_t;

    state_t            state;
    state_t            state_nxt;
    logic [IDX_W-1:0]  rr_ptr;
    logic [IDX_W-1:0]  grant_idx;
    logic [NREQ-1:0]   grant_vec;
    logic              grant_any;
    logic              accept;
    logic              timeout_hit;

    function automatic int wrap_idx(input int base, input int off);
        return (base + off) % NREQ;
    endfunction

    // Round-robin scan starting just after the last granted requester, so the
    // requester granted last has the lowest priority next time.
    // NOTE: every variable written here gets a default first; a path that
    // skipped an assignment would infer a latch.
    always_comb begin
        grant_vec = '0;
        grant_idx = '0;
        grant_any = 1'b0;
        for (int off = 1; off <= NREQ; off++) begin
            if (!grant_any && req_valid[wrap_idx(int'(rr_ptr), off)]) begin
                grant_any                                 = 1'b1;
                grant_idx                                 = IDX_W'(wrap_idx(int'(rr_ptr), off));
                grant_vec[wrap_idx(int'(rr_ptr), off)]    = 1'b1;
            end
        end
    end

    // The reset term keeps req_ready low while reset is held, even though the
    // state register already sits in IDLE.
    assign req_ready  = (state == S_IDLE && rst) ? grant_vec : '0;
    assign accept     = (state == S_IDLE) && grant_any;

    // Status outputs decode the registered state, so an async reset drops
    // them immediately without waiting for an edge.
    assign core_start = (state == S_RUN);
    assign rsp_valid  = (state == S_RESP);
    assign busy       = (state != S_IDLE);

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:  if (accept)                   state_nxt = S_RUN;
            S_RUN:   if (core_done || timeout_hit) state_nxt = S_RESP;
            S_RESP:  if (rsp_ready)                state_nxt = S_IDLE;
            default:                               state_nxt = S_IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state       <= S_IDLE;
            rr_ptr      <= IDX_W'(NREQ - 1);
            core_matrix <= '0;
            rsp_id      <= '0;
            rsp_matrix  <= '0;
        end else begin
            state <= state_nxt;
            if (accept) begin
                core_matrix <= req_matrix[grant_idx*MAT_W +: MAT_W];
                rsp_id      <= grant_idx;
                rr_ptr      <= grant_idx;
            end
            // core_done takes priority over an expiring timer on the same edge.
            if (state == S_RUN && core_done) begin
                rsp_matrix <= core_matrix_out;
            end else if (timeout_hit) begin
                rsp_matrix <= '0;
            end
        end
    end

`ifdef MINV_TIMEOUT_EN
    localparam int TMR_W = $clog2(TIMEOUT_CYC + 1);

    logic [TMR_W-1:0] run_cyc;
    logic             timeout_q;

    // run_cyc holds the number of RUN cycles already completed, so the limit
    // fires on the edge that ends the TIMEOUT_CYC-th RUN cycle.
    assign timeout_hit = (state == S_RUN) && !core_done &&
                         (run_cyc == TMR_W'(TIMEOUT_CYC - 1));
    assign rsp_timeout = timeout_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            run_cyc   <= '0;
            timeout_q <= 1'b0;
        end else begin
            if (accept) begin
                run_cyc <= '0;
            end else if (state == S_RUN) begin
                run_cyc <= run_cyc + TMR_W'(1);
            end
            if (timeout_hit) begin
                timeout_q <= 1'b1;
            end else if (state == S_RESP && rsp_ready) begin
                timeout_q <= 1'b0;
            end
        end
    end
`else
    assign timeout_hit = 1'b0;
    assign rsp_timeout = 1'b0;
`endif

endmodule

// File: tb/tb_minv_job_arbiter.sv
// -----------------------------------------------------------------------------
// tb_minv_job_arbiter
//
// Directed bench for minv_job_arbiter with NREQ=4, ELEM_W=8, TIMEOUT_CYC=16.
// Inputs are driven at the falling clock edge and outputs sampled 1 time unit
// later, away from the rising edge. The core is played by the stimulus itself.
// -----------------------------------------------------------------------------
module tb_minv_job_arbiter;

    localparam int NREQ   = 4;
    localparam int ELEM_W = 8;
    localparam int MAT_W  = 9 * ELEM_W;
    localparam int IDX_W  = 2;

    logic                   clk = 1'b0;
    logic                   rst;
    logic [NREQ-1:0]        req_valid;
    logic [NREQ*MAT_W-1:0]  req_matrix;
    logic [NREQ-1:0]        req_ready;
    logic                   core_start;
    logic [MAT_W-1:0]       core_matrix;
    logic                   core_done;
    logic [MAT_W-1:0]       core_matrix_out;
    logic                   rsp_valid;
    logic                   rsp_ready;
    logic [IDX_W-1:0]       rsp_id;
    logic [MAT_W-1:0]       rsp_matrix;
    logic                   rsp_timeout;
    logic                   busy;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    minv_job_arbiter #(
        .NREQ        (NREQ),
        .ELEM_W      (ELEM_W),
        .MAT_W       (MAT_W),
        .IDX_W       (IDX_W),
        .TIMEOUT_CYC (16)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .req_valid       (req_valid),
        .req_matrix      (req_matrix),
        .req_ready       (req_ready),
        .core_start      (core_start),
        .core_matrix     (core_matrix),
        .core_done       (core_done),
        .core_matrix_out (core_matrix_out),
        .rsp_valid       (rsp_valid),
        .rsp_ready       (rsp_ready),
        .rsp_id          (rsp_id),
        .rsp_matrix      (rsp_matrix),
        .rsp_timeout     (rsp_timeout),
        .busy            (busy)
    );

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_cmp++;
        assert (obs === exp)
        else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    function automatic logic [MAT_W-1:0] mk9(input int a, input int b, input int c,
                                             input int d, input int e, input int f,
                                             input int g, input int h, input int k);
        logic [MAT_W-1:0] m;
        m = {ELEM_W'(k), ELEM_W'(h), ELEM_W'(g), ELEM_W'(f), ELEM_W'(e),
             ELEM_W'(d), ELEM_W'(c), ELEM_W'(b), ELEM_W'(a)};
        return m;
    endfunction

    function automatic logic [MAT_W-1:0] mk_seq(input int base);
        return mk9(base, base + 1, base + 2, base + 3, base + 4,
                   base + 5, base + 6, base + 7, base + 8);
    endfunction

    initial begin
        logic [MAT_W-1:0] m1;
        logic [MAT_W-1:0] r1;
        logic [MAT_W-1:0] rr;
        logic [3:0]       oh;
        int               hi;
        int               exp_order [8];
        int               n_rsp;
        int               n_start;
        int               min_gap;
        int               low_run;
        int               cnt;
        logic             prev_start;
        logic             seen_high;

        exp_order = '{1, 2, 3, 0, 1, 2, 3, 0};
        m1 = mk9(1, 2, 3, 2, 1, 5, 3, 5, 6);
        r1 = mk9(8'hF1, 8'h03, 8'h07, 8'h09, 8'hFD, 8'h01, 8'h07, 8'h01, 8'hFD);

        // ---------------- reset ----------------
        rst             = 1'b0;
        req_valid       = 4'b1111;
        req_matrix      = '0;
        core_done       = 1'b0;
        core_matrix_out = '0;
        rsp_ready       = 1'b0;
        tick();
        #1;
        check("rst_ctrl", 128'({core_start, rsp_valid, rsp_timeout, busy, req_ready}), 128'(8'h00));
        check("rst_data", 128'({core_matrix, rsp_id}), 128'(0));
        check("rst_rsp_matrix", 128'(rsp_matrix), 128'(0));

        // ---------------- T1 single job, 20-cycle core ----------------
        tick();
        rst                   = 1'b1;
        req_valid             = 4'b0001;
        req_matrix[0 +: MAT_W] = m1;
        #1;
        check("t1_grant", 128'({req_ready, busy}), 128'({4'b0001, 1'b0}));
        tick();
        #1;
        check("t1_run", 128'({core_start, busy, req_ready, rsp_valid}), 128'({1'b1, 1'b1, 4'b0000, 1'b0}));
        check("t1_core_matrix", 128'(core_matrix), 128'(m1));
        check("t1_id_latched", 128'(rsp_id), 128'(0));
        req_valid = 4'b0000;
        hi = 1;
        for (int c = 2; c <= 20; c++) begin
            tick();
            if (core_start) hi++;
            if (c == 20) begin
                core_done       = 1'b1;
                core_matrix_out = r1;
            end
        end
        tick();
        core_done = 1'b0;
        #1;
        check("t1_start_cycles", 128'(hi), 128'(20));
        check("t1_resp_ctrl", 128'({rsp_valid, core_start, rsp_timeout}), 128'(3'b100));
        check("t1_resp_data", 128'({rsp_id, rsp_matrix}), 128'({2'd0, r1}));
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
        #1;
        check("t1_idle", 128'({rsp_valid, busy}), 128'(2'b00));

        // ---------------- T2 round robin, all requesting ----------------
        for (int i = 0; i < NREQ; i++) req_matrix[i*MAT_W +: MAT_W] = mk_seq((i + 1) * 16);
        req_valid = 4'b1111;
        rsp_ready = 1'b1;
        for (int j = 0; j < 8; j++) begin
            #1;
            oh = 4'b0001 << exp_order[j];
            check("t2_grant", 128'(req_ready), 128'(oh));
            tick();
            #1;
            check("t2_run", 128'({core_start, rsp_id}), 128'({1'b1, 2'(exp_order[j])}));
            check("t2_core_matrix", 128'(core_matrix), 128'(mk_seq((exp_order[j] + 1) * 16)));
            core_done       = 1'b1;
            core_matrix_out = mk_seq(100 + j * 10);
            tick();
            core_done = 1'b0;
            #1;
            check("t2_resp", 128'({rsp_valid, core_start, rsp_matrix}), 128'({1'b1, 1'b0, mk_seq(100 + j * 10)}));
            tick();
        end

        // ---------------- T3 backpressure ----------------
        rsp_ready = 1'b0;
        #1;
        check("t3_grant", 128'(req_ready), 128'(4'b0010));
        tick();
        core_done       = 1'b1;
        rr              = mk_seq(200);
        core_matrix_out = rr;
        tick();
        core_done       = 1'b0;
        core_matrix_out = '0;
        for (int k = 0; k < 10; k++) begin
            #1;
            check("t3_hold", 128'({rsp_valid, core_start, req_ready, rsp_id, rsp_matrix}),
                  128'({1'b1, 1'b0, 4'b0000, 2'd1, rr}));
            tick();
        end
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;

        // ---------------- T4 async reset in RUN ----------------
        #1;
        check("t4_grant", 128'(req_ready), 128'(4'b0100));
        tick();
        #1;
        check("t4_run", 128'({core_start, rsp_id}), 128'({1'b1, 2'd2}));
        #2;
        rst = 1'b0;
        #1;
        check("t4_rst_ctrl", 128'({core_start, busy, rsp_valid, req_ready}), 128'(7'b0));
        check("t4_rst_data", 128'({rsp_id, core_matrix}), 128'(0));
        tick();
        rst = 1'b1;
        #1;
        check("t4_regrant", 128'(req_ready), 128'(4'b0001));
        tick();
        #1;
        check("t4_run_id", 128'({core_start, rsp_id}), 128'({1'b1, 2'd0}));
        core_done       = 1'b1;
        core_matrix_out = mk_seq(50);
        tick();
        core_done = 1'b0;
        rsp_ready = 1'b1;
        #1;
        check("t4_resp", 128'({rsp_valid, rsp_matrix}), 128'({1'b1, mk_seq(50)}));
        tick();
        rsp_ready = 1'b0;

`ifdef MINV_TIMEOUT_EN
        // ---------------- T5 timeout ----------------
        req_valid = 4'b1000;
        #1;
        check("t5_grant", 128'(req_ready), 128'(4'b1000));
        tick();
        hi = 0;
        for (int g = 0; g < 40 && !rsp_valid; g++) begin
            if (core_start) hi++;
            tick();
        end
        #1;
        check("t5_run_cycles", 128'(hi), 128'(16));
        check("t5_resp", 128'({rsp_valid, rsp_timeout, core_start, rsp_id}), 128'({1'b1, 1'b1, 1'b0, 2'd3}));
        check("t5_zero_matrix", 128'(rsp_matrix), 128'(0));
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
        #1;
        check("t5_cleared", 128'({rsp_timeout, busy}), 128'(2'b00));
        req_valid = 4'b0001;
        #1;
        check("t5_next_grant", 128'(req_ready), 128'(4'b0001));
        tick();
        core_done       = 1'b1;
        core_matrix_out = mk_seq(60);
        tick();
        core_done = 1'b0;
        #1;
        check("t5_next_resp", 128'({rsp_valid, rsp_timeout, rsp_matrix}), 128'({1'b1, 1'b0, mk_seq(60)}));
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
`endif

        // ---------------- T6 core holds done until start falls ----------------
        req_valid  = 4'b1111;
        rsp_ready  = 1'b1;
        core_done  = 1'b0;
        n_rsp      = 0;
        n_start    = 0;
        min_gap    = 99;
        low_run    = 0;
        cnt        = 0;
        prev_start = 1'b0;
        seen_high  = 1'b0;
        for (int j = 0; j < 22; j++) begin
            #1;
            if (rsp_valid) n_rsp++;
            if (core_start) begin
                if (!prev_start) begin
                    n_start++;
                    if (seen_high && low_run < min_gap) min_gap = low_run;
                end
                seen_high = 1'b1;
                low_run   = 0;
                cnt++;
                core_done = (cnt >= 2);
            end else begin
                low_run++;
                cnt = 0;
                if (!prev_start) core_done = 1'b0;
            end
            core_matrix_out = mk_seq(j);
            prev_start      = core_start;
            tick();
        end
        check("t6_starts", 128'(n_start), 128'(6));
        check("t6_responses", 128'(n_rsp), 128'(5));
        check("t6_start_gap", 128'(min_gap >= 1 && min_gap < 99), 128'(1'b1));

        req_valid = 4'b0000;
        core_done = 1'b0;
        rsp_ready = 1'b0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
